// File: rtl/store_commit_buffer_if.sv
// Commit-time store port, memory write handshake and load-check lookup of the
// store commit buffer. The buffer is the slave; the ROB/memory side is the master.
interface store_commit_buffer_if;
  // ROB commit port: a cacheWriteEnable pulse is taken on an edge only while cacheWriteDone is high.
  logic        cacheWriteEnable;
  logic [31:0] cacheWriteAddr;
  logic [31:0] cacheWriteData;
  logic [1:0]  cacheWriteSize;
  logic        cacheWriteDone;

  // Memory write: memWriteEnable and the payload stay stable until an edge with memWriteAck=1.
  logic        memWriteEnable;
  logic [31:0] memWriteAddr;
  logic [31:0] memWriteData;
  logic [3:0]  memWriteMask;
  logic        memWriteAck;

  logic [31:0] loadCheckAddr;
  logic        loadConflict;

  modport master (
    output cacheWriteEnable, cacheWriteAddr, cacheWriteData, cacheWriteSize,
    input  cacheWriteDone,
    input  memWriteEnable, memWriteAddr, memWriteData, memWriteMask,
    output memWriteAck,
    output loadCheckAddr,
    input  loadConflict
  );

  modport slave (
    input  cacheWriteEnable, cacheWriteAddr, cacheWriteData, cacheWriteSize,
    output cacheWriteDone,
    output memWriteEnable, memWriteAddr, memWriteData, memWriteMask,
    input  memWriteAck,
    input  loadCheckAddr,
    output loadConflict
  );
endinterface

// File: rtl/store_commit_buffer.sv
// Store commit buffer: queues committed stores in a small FIFO, drains them to
// memory one request at a time and flags loads that hit a pending store word.
module store_commit_buffer #(
    parameter int DEPTH = 4,
    parameter int PTR_W = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  resetAll,
    store_commit_buffer_if.slave  bus,
    output logic                  bufferEmpty,
    output logic                  overflowErr,
    output logic                  state_dbg
);

    typedef enum logic {
        IDLE = 1'b0,
        REQ  = 1'b1
    } state_t;

    localparam logic [PTR_W:0] FULL_CNT = DEPTH[PTR_W:0];

    state_t           state_q, state_d;
    logic [PTR_W-1:0] head_q, tail_q;
    logic [PTR_W:0]   count_q;
    logic [DEPTH-1:0] valid_q;
    logic [31:0]      addr_mem [DEPTH];
    logic [31:0]      data_mem [DEPTH];
    logic [1:0]       size_mem [DEPTH];

    logic        push, pop, load_req, conflict;
    logic        mem_en_q;
    logic [31:0] mem_addr_q, mem_data_q;
    logic [3:0]  mem_mask_q;
    logic [3:0]  head_mask;
    logic [31:0] head_data;

    // Committed stores are architectural, so a pipeline flush must not touch them.
    logic unused_inputs;
    assign unused_inputs = ^{resetAll, bus.loadCheckAddr[1:0]};

    assign push = bus.cacheWriteEnable && (count_q < FULL_CNT);

    // Byte-lane formation for the head entry; size 3 drains like a word store.
    always_comb begin
        head_mask = 4'b1111;
        head_data = data_mem[head_q];
        case (size_mem[head_q])
            2'd0: begin
                head_mask = 4'b0001 << addr_mem[head_q][1:0];
                head_data = {4{data_mem[head_q][7:0]}};
            end
            2'd1: begin
                head_mask = 4'b0011 << {addr_mem[head_q][1], 1'b0};
                head_data = {2{data_mem[head_q][15:0]}};
            end
            default: begin
                head_mask = 4'b1111;
                head_data = data_mem[head_q];
            end
        endcase
    end

    always_comb begin
        state_d  = state_q;
        load_req = 1'b0;
        pop      = 1'b0;
        case (state_q)
            IDLE: begin
                if (count_q != '0) begin
                    load_req = 1'b1;
                    state_d  = REQ;
                end
            end
            REQ: begin
                if (bus.memWriteAck) begin
                    pop     = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            head_q      <= '0;
            tail_q      <= '0;
            count_q     <= '0;
            valid_q     <= '0;
            overflowErr <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                addr_mem[i] <= '0;
                data_mem[i] <= '0;
                size_mem[i] <= '0;
            end
        end else begin
            // Clear before set: head and tail only coincide when no push/pop pair is possible.
            if (pop) begin
                valid_q[head_q] <= 1'b0;
                head_q          <= head_q + 1'b1;
            end
            if (push) begin
                addr_mem[tail_q] <= bus.cacheWriteAddr;
                data_mem[tail_q] <= bus.cacheWriteData;
                size_mem[tail_q] <= bus.cacheWriteSize;
                valid_q[tail_q]  <= 1'b1;
                tail_q           <= tail_q + 1'b1;
            end
            case ({push, pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
            if (bus.cacheWriteEnable && (count_q == FULL_CNT)) begin
                overflowErr <= 1'b1;
            end
        end
    end

    // Request payload is captured once on entry to REQ and held until the ack edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mem_en_q   <= 1'b0;
            mem_addr_q <= '0;
            mem_data_q <= '0;
            mem_mask_q <= '0;
        end else if (load_req) begin
            mem_en_q   <= 1'b1;
            mem_addr_q <= {addr_mem[head_q][31:2], 2'b00};
            mem_data_q <= head_data;
            mem_mask_q <= head_mask;
        end else if (pop) begin
            mem_en_q <= 1'b0;
        end
    end

    always_comb begin
        conflict = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (valid_q[i] && (addr_mem[i][31:2] == bus.loadCheckAddr[31:2])) begin
                conflict = 1'b1;
            end
        end
    end

    assign bus.cacheWriteDone = (count_q < FULL_CNT);
    assign bus.memWriteEnable = mem_en_q;
    assign bus.memWriteAddr   = mem_addr_q;
    assign bus.memWriteData   = mem_data_q;
    assign bus.memWriteMask   = mem_mask_q;
    assign bus.loadConflict   = conflict;
    assign bufferEmpty        = (count_q == '0) && (state_q == IDLE);
    assign state_dbg          = state_q;

endmodule

// File: tb/tb_store_commit_buffer.sv
// Self-checking bench for store_commit_buffer: stores are modelled into an
// expected queue at push time and compared when each memory request appears.
module tb_store_commit_buffer;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic resetAll = 1'b0;
  logic bufferEmpty, overflowErr, state_dbg;

  always #5 clk = ~clk;

  store_commit_buffer_if sif ();

  store_commit_buffer #(.DEPTH(4), .PTR_W(2)) dut (
    .clk         (clk),
    .rst         (rst),
    .resetAll    (resetAll),
    .bus         (sif.slave),
    .bufferEmpty (bufferEmpty),
    .overflowErr (overflowErr),
    .state_dbg   (state_dbg)
  );

  int n_checks = 0;
  int n_errors = 0;
  int n_req = 0;

  // {word address, lane data, mask}
  logic [67:0] exp_q[$];
  logic [67:0] held = '0;
  logic        prev_en = 1'b0;
  logic        manual_ack = 1'b0;
  logic        auto_ack = 1'b0;
  logic        auto_ack_r = 1'b0;

  assign sif.memWriteAck = manual_ack | auto_ack_r;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  function automatic logic [67:0] model(input logic [31:0] a, input logic [31:0] d,
                                        input logic [1:0] s);
    logic [3:0]  m;
    logic [31:0] w;
    case (s)
      2'd0: begin
        m = 4'(1 << a[1:0]);
        w = d[7:0] * 32'h0101_0101;
      end
      2'd1: begin
        m = a[1] ? 4'hC : 4'h3;
        w = d[15:0] * 32'h0001_0001;
      end
      default: begin
        m = 4'hF;
        w = d;
      end
    endcase
    return {a[31:2], 2'b00, w, m};
  endfunction

  // Monitor: a rising request is compared with the queue head; a held request must not change.
  always @(negedge clk) begin
    if (sif.memWriteEnable && !prev_en) begin
      n_req++;
      check("write_expected", 32'(exp_q.size() != 0), 32'd1);
      if (exp_q.size() != 0) begin
        held = exp_q.pop_front();
        check("mem_addr", sif.memWriteAddr, held[67:36]);
        check("mem_data", sif.memWriteData, held[35:4]);
        check("mem_mask", 32'(sif.memWriteMask), 32'(held[3:0]));
      end
    end else if (sif.memWriteEnable && prev_en) begin
      check("hold_addr", sif.memWriteAddr, held[67:36]);
      check("hold_mask", 32'(sif.memWriteMask), 32'(held[3:0]));
    end
    prev_en    = sif.memWriteEnable;
    auto_ack_r = auto_ack && sif.memWriteEnable;
  end

  task automatic push_store(input logic [31:0] a, input logic [31:0] d, input logic [1:0] s,
                            input logic acc);
    check("done_before_push", 32'(sif.cacheWriteDone), 32'(acc));
    sif.cacheWriteEnable = 1'b1;
    sif.cacheWriteAddr   = a;
    sif.cacheWriteData   = d;
    sif.cacheWriteSize   = s;
    if (acc) exp_q.push_back(model(a, d, s));
    @(negedge clk);
    sif.cacheWriteEnable = 1'b0;
  endtask

  task automatic wait_req(input string tag);
    int g = 0;
    while (!sif.memWriteEnable && g < 20) begin
      @(negedge clk);
      g++;
    end
    check(tag, 32'(sif.memWriteEnable), 32'd1);
  endtask

  task automatic wait_empty(input string tag);
    int g = 0;
    while (!bufferEmpty && g < 200) begin
      @(negedge clk);
      g++;
    end
    check(tag, 32'(bufferEmpty), 32'd1);
    check({tag, "_queue"}, 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int saved_req;
    int g;
    sif.cacheWriteEnable = 1'b0;
    sif.cacheWriteAddr   = '0;
    sif.cacheWriteData   = '0;
    sif.cacheWriteSize   = '0;
    sif.loadCheckAddr    = 32'hFFFF_FFF0;

    // Reset values
    repeat (2) @(negedge clk);
    check("rst_mem_en", 32'(sif.memWriteEnable), 32'd0);
    check("rst_mem_addr", sif.memWriteAddr, 32'd0);
    check("rst_mem_data", sif.memWriteData, 32'd0);
    check("rst_mem_mask", 32'(sif.memWriteMask), 32'd0);
    check("rst_overflow", 32'(overflowErr), 32'd0);
    check("rst_done", 32'(sif.cacheWriteDone), 32'd1);
    check("rst_empty", 32'(bufferEmpty), 32'd1);
    check("rst_conflict", 32'(sif.loadConflict), 32'd0);
    rst = 1'b0;
    @(negedge clk);

    // Single SW with one-edge request latency and a one-cycle ack
    push_store(32'h0000_0104, 32'hDEAD_BEEF, 2'd2, 1'b1);
    check("latency_en_low", 32'(sif.memWriteEnable), 32'd0);
    check("latency_not_empty", 32'(bufferEmpty), 32'd0);
    @(negedge clk);
    check("latency_en_high", 32'(sif.memWriteEnable), 32'd1);
    manual_ack = 1'b1;
    @(negedge clk);
    manual_ack = 1'b0;
    check("single_en_drop", 32'(sif.memWriteEnable), 32'd0);
    check("single_empty", 32'(bufferEmpty), 32'd1);

    // Byte, halfword and reserved-size lanes
    auto_ack = 1'b1;
    push_store(32'h0000_0203, 32'h0000_00AB, 2'd0, 1'b1);
    push_store(32'h0000_0206, 32'h0000_1234, 2'd1, 1'b1);
    push_store(32'h0000_0208, 32'h5566_7788, 2'd3, 1'b1);
    push_store(32'h0000_0201, 32'h0000_00C3, 2'd0, 1'b1);
    push_store(32'h0000_0211, 32'h0000_9ABC, 2'd1, 1'b1);
    wait_empty("lanes_drain");

    // Streaming with wrap and push/pop in the same cycle
    for (int i = 0; i < 10; i++) begin
      g = 0;
      while (!sif.cacheWriteDone && g < 20) begin
        @(negedge clk);
        g++;
      end
      push_store(32'(i * 4), 32'hA000_0000 + 32'($urandom_range(0, 16'hFFFF)), 2'd2, 1'b1);
    end
    wait_empty("stream_drain");
    check("stream_no_overflow", 32'(overflowErr), 32'd0);

    // Full and overflow
    auto_ack = 1'b0;
    @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      push_store(32'h0000_1000 + 32'(i * 4), 32'hC0DE_0000 + 32'(i), 2'd2, 1'b1);
    end
    check("full_done_low", 32'(sif.cacheWriteDone), 32'd0);
    push_store(32'h0000_1FF0, 32'hBAD0_BAD0, 2'd2, 1'b0);
    check("overflow_set", 32'(overflowErr), 32'd1);
    // Pop and push in the same cycle while full: the push must still be dropped.
    manual_ack = 1'b1;
    sif.cacheWriteEnable = 1'b1;
    sif.cacheWriteAddr   = 32'h0000_1FF4;
    check("full_pop_done_low", 32'(sif.cacheWriteDone), 32'd0);
    @(negedge clk);
    manual_ack = 1'b0;
    sif.cacheWriteEnable = 1'b0;
    check("done_after_pop", 32'(sif.cacheWriteDone), 32'd1);
    auto_ack = 1'b1;
    wait_empty("full_drain");
    check("overflow_sticky", 32'(overflowErr), 32'd1);

    // Load conflict, including the in-flight entry
    auto_ack = 1'b0;
    @(negedge clk);
    push_store(32'h0000_0300, 32'h1111_1111, 2'd2, 1'b1);
    push_store(32'h0000_0411, 32'h0000_0022, 2'd0, 1'b1);
    wait_req("conf_req");
    sif.loadCheckAddr = 32'h0000_0302;
    #1 check("conflict_302", 32'(sif.loadConflict), 32'd1);
    sif.loadCheckAddr = 32'h0000_0410;
    #1 check("conflict_410", 32'(sif.loadConflict), 32'd1);
    sif.loadCheckAddr = 32'h0000_0304;
    #1 check("conflict_304", 32'(sif.loadConflict), 32'd0);
    auto_ack = 1'b1;
    wait_empty("conf_drain");
    sif.loadCheckAddr = 32'h0000_0300;
    #1 check("conflict_after_drain", 32'(sif.loadConflict), 32'd0);

    // Flush leaves committed stores in place
    auto_ack = 1'b0;
    @(negedge clk);
    push_store(32'h0000_0600, 32'h6666_0000, 2'd2, 1'b1);
    push_store(32'h0000_0604, 32'h6666_0004, 2'd2, 1'b1);
    resetAll = 1'b1;
    @(negedge clk);
    resetAll = 1'b0;
    check("flush_done", 32'(sif.cacheWriteDone), 32'd1);
    check("flush_not_empty", 32'(bufferEmpty), 32'd0);
    auto_ack = 1'b1;
    wait_empty("flush_drain");

    // Reset during REQ drops the in-flight write; a late ack is ignored
    auto_ack = 1'b0;
    @(negedge clk);
    push_store(32'h0000_0500, 32'h5555_0000, 2'd2, 1'b1);
    push_store(32'h0000_0504, 32'h5555_0004, 2'd2, 1'b1);
    wait_req("rst_req");
    sif.loadCheckAddr = 32'h0000_0500;
    rst = 1'b1;
    #1;
    check("midrst_en", 32'(sif.memWriteEnable), 32'd0);
    check("midrst_empty", 32'(bufferEmpty), 32'd1);
    check("midrst_done", 32'(sif.cacheWriteDone), 32'd1);
    check("midrst_overflow", 32'(overflowErr), 32'd0);
    check("midrst_conflict", 32'(sif.loadConflict), 32'd0);
    exp_q.delete();
    @(negedge clk);
    rst = 1'b0;
    saved_req = n_req;
    manual_ack = 1'b1;
    @(negedge clk);
    manual_ack = 1'b0;
    repeat (3) @(negedge clk);
    check("late_ack_no_write", 32'(n_req), 32'(saved_req));
    check("late_ack_en", 32'(sif.memWriteEnable), 32'd0);
    check("late_ack_empty", 32'(bufferEmpty), 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/store_commit_buffer.md
Name: store_commit_buffer

Overview:
- Responder for the reorder buffer's commit-time store port: cacheWriteEnable, cacheWriteAddr, cacheWriteData and cacheWriteSize in; cacheWriteDone out.
- Absorbs committed stores into a small FIFO and drains them to the data memory over a req/ack write handshake.
- Flags loads that hit a pending store address so the load unit can stall.
- Committed stores are architectural state, so a pipeline flush never discards them.

Parameters:
- DEPTH, 4, number of FIFO entries (power of two, at least 2).
- PTR_W, 2, pointer width, equal to log2(DEPTH).

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  reset, asynchronous, active-high.
- cacheWriteEnable  in  1  one-cycle store-commit pulse from the ROB.
- cacheWriteAddr  in  32  byte address of the store.
- cacheWriteData  in  32  store data, right-aligned.
- cacheWriteSize  in  2  store width: 0 = SB, 1 = SH, 2 = SW, 3 = reserved.
- cacheWriteDone  out  1  high when a commit can be accepted this cycle.
- resetAll  in  1  pipeline flush; has no effect on buffer contents (see Behaviour).
- memWriteEnable  out  1  write request to memory.
- memWriteAddr  out  32  word-aligned address, {addr[31:2], 2'b00}.
- memWriteData  out  32  data lane-shifted to its byte position.
- memWriteMask  out  4  byte enables.
- memWriteAck  in  1  memory accepted the write.
- loadCheckAddr  in  32  address of a pending load.
- loadConflict  out  1  loadCheckAddr word matches an unretired store.
- bufferEmpty  out  1  no entries and no write in flight.
- overflowErr  out  1  sticky: a push arrived while full.

Behaviour:
- Reset (asynchronous, active-high):
  - head, tail and count go to 0; FSM goes to IDLE.
  - memWriteEnable=0, memWriteAddr=0, memWriteData=0, memWriteMask=0.
  - overflowErr=0, cacheWriteDone=1, bufferEmpty=1, loadConflict=0.
  - Reset mid-handshake drops the in-flight write; the memory must ignore a late ack.
- cacheWriteDone = (count < DEPTH), from registered count only.
  - A pop in the same cycle does not make room for a push in that cycle.
- Push, on a clk edge with cacheWriteEnable=1 and count<DEPTH:
  - Store {addr, data, size} at tail; tail=tail+1 mod DEPTH, wrapping at DEPTH-1 to 0.
  - With count=DEPTH the push is dropped, overflowErr is set to 1 and holds until reset.
- Size 3 (reserved) is stored and drained as SW.
- Byte-lane formation, with o = addr[1:0]:
  - SB: mask = 4'b0001 << o; data = {4{data[7:0]}}.
  - SH: mask = 4'b0011 << {o[1],1'b0}; data = {2{data[15:0]}}.
  - SW: mask = 4'b1111; data unchanged.
  - Misalignment within a halfword or word is ignored, not trapped.
- FSM states: IDLE, REQ.
  - IDLE: if count>0, register head entry into the mem* outputs, set memWriteEnable=1, go to REQ.
  - REQ: hold all mem* outputs stable. On an edge with memWriteAck=1: memWriteEnable=0, pop head (head+1 mod DEPTH, count-1), go to IDLE.
  - There is one idle cycle between successive writes.
  - Latency: a push at edge N gives memWriteEnable high after edge N+1, at the earliest.
- Simultaneous push and pop: count is unchanged; both pointers advance.
- loadConflict (combinational):
  - High if any occupied entry, including the one in flight, has addr[31:2] == loadCheckAddr[31:2].
  - Low when count=0.
- bufferEmpty = (count==0) and state==IDLE.
- resetAll (flush) is ignored: committed stores still drain, and cacheWriteDone keeps its normal meaning.
- memWriteAck while in IDLE is ignored.
- Reset values of outputs are as listed above; no output is X after reset.

Test Plan:
- Single SW: push addr=0x00000104, data=0xDEADBEEF, size=2. Required: memWriteEnable rises after the next edge with addr=0x104, mask=4'b1111, data=0xDEADBEEF. Ack held for 1 cycle → bufferEmpty=1 two edges later.
- Byte/half lanes: SB addr=0x203, data=0x000000AB → mask=4'b1000, data=0xABABABAB. SH addr=0x206, data=0x00001234 → mask=4'b1100, data=0x12341234.
- Full / overflow: tie ack=0, push 4 stores → cacheWriteDone=0. A 5th push → dropped and overflowErr=1. Then pulse ack once → cacheWriteDone=1 after that edge; the drain order matches the push order.
- Wrap and simultaneous push/pop: stream 10 SW stores to addresses 0x0, 0x4, … 0x24, with ack returned 1 cycle after each request and a push in the same cycle as every pop. Required: count never exceeds DEPTH, all 10 reach memory in order, and the pointers wrap correctly.
- Load conflict: buffer holds SW 0x300 (still in flight) and SB 0x411. loadCheckAddr=0x302 → conflict=1; 0x410 → 1; 0x304 → 0. After both stores are acked, 0x300 → 0.
- Flush and reset: with 2 entries queued, pulse resetAll → both still drain. Then queue 2 more, and assert rst during REQ → memWriteEnable=0 immediately, bufferEmpty=1, a late ack causes no write.
